// File: rtl/tlul_pkg.sv
// ============================================================================
// Module  : tlul_pkg
// Brief   : TL-UL opcodes, default channel widths and the D-channel response record.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tlul_pkg;

   localparam int TL_OPCODE_W = 3;
   localparam int TL_PARAM_W  = 3;
   localparam int TL_SIZE_W   = 3;
   localparam int TL_SRC_W    = 2;
   localparam int TL_SINK_W   = 1;
   localparam int TL_ADDR_W   = 32;
   localparam int TL_DATA_W   = 32;
   localparam int TL_MASK_W   = TL_DATA_W / 8;

   typedef enum logic [TL_OPCODE_W-1:0] {
      PUT_FULL_DATA    = 3'd0,
      PUT_PARTIAL_DATA = 3'd1,
      GET              = 3'd4
   } tl_a_op_e;

   typedef enum logic [TL_OPCODE_W-1:0] {
      ACCESS_ACK      = 3'd0,
      ACCESS_ACK_DATA = 3'd1
   } tl_d_op_e;

   typedef struct packed {
      logic [TL_OPCODE_W-1:0] opcode;
      logic [TL_SIZE_W-1:0]   size;
      logic [TL_SRC_W-1:0]    source;
      logic [TL_DATA_W-1:0]   data;
      logic                   error;
   } d_resp_t;

   localparam int D_RESP_W = $bits(d_resp_t);

endpackage

`default_nettype wire

// File: rtl/tlul_resp_fifo.sv
// ============================================================================
// Module  : tlul_resp_fifo
// Brief   : Small circular FIFO holding pending D-channel responses; head is zero when empty.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tlul_resp_fifo
   import tlul_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = D_RESP_W,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == C_DEPTH);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = o_empty ? '0 : r_mem[r_rptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == C_LAST) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == C_LAST) ? '0 : r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage carries no reset; validity is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_push_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/tlul_sram_responder.sv
// ============================================================================
// Module  : tlul_sram_responder
// Brief   : TL-UL slave endpoint backed by a byte-masked word SRAM and a response FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tlul_sram_responder
   import tlul_pkg::*;
#(
   parameter int OPCODE_WIDTH = TL_OPCODE_W,
   parameter int PARAM_WIDTH  = TL_PARAM_W,
   parameter int SIZE_WIDTH   = TL_SIZE_W,
   parameter int SRC_WIDTH    = TL_SRC_W,
   parameter int SINK_WIDTH   = TL_SINK_W,
   parameter int ADDR_WIDTH   = TL_ADDR_W,
   parameter int DATA_WIDTH   = TL_DATA_W,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int MEM_WORDS    = 1024,
   parameter int RESP_DEPTH   = 2,
   localparam int MASK_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    a_valid,
   output logic                    a_ready,
   input  logic [OPCODE_WIDTH-1:0] a_opcode,
   input  logic [PARAM_WIDTH-1:0]  a_param,
   input  logic [SIZE_WIDTH-1:0]   a_size,
   input  logic [SRC_WIDTH-1:0]    a_source,
   input  logic [ADDR_WIDTH-1:0]   a_address,
   input  logic [MASK_WIDTH-1:0]   a_mask,
   input  logic [DATA_WIDTH-1:0]   a_data,
   output logic                    d_valid,
   input  logic                    d_ready,
   output logic [OPCODE_WIDTH-1:0] d_opcode,
   output logic [PARAM_WIDTH-1:0]  d_param,
   output logic [SIZE_WIDTH-1:0]   d_size,
   output logic [SRC_WIDTH-1:0]    d_source,
   output logic [SINK_WIDTH-1:0]   d_sink,
   output logic [DATA_WIDTH-1:0]   d_data,
   output logic                    d_error
);

   localparam int C_LG_MASK = $clog2(MASK_WIDTH);
   localparam int C_IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int C_ENTRY_W = OPCODE_WIDTH + SIZE_WIDTH + SRC_WIDTH + DATA_WIDTH + 1;
   localparam int C_CNT_W   = $clog2(RESP_DEPTH + 1);
   localparam logic [ADDR_WIDTH:0]   C_MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_WORDS * MASK_WIDTH);
   localparam logic [SIZE_WIDTH-1:0] C_MAX_SIZE  = SIZE_WIDTH'(C_LG_MASK);

   logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

   logic                    w_fire;
   logic [ADDR_WIDTH-1:0]   w_off;
   logic [C_IDX_W-1:0]      w_idx;
   logic                    w_is_get;
   logic                    w_is_pfull;
   logic                    w_is_put;
   logic                    w_in_range;
   logic                    w_size_bad;
   logic                    w_misalign;
   logic [MASK_WIDTH-1:0]   w_full_mask;
   logic                    w_error;
   logic                    w_we;
   logic [OPCODE_WIDTH-1:0] w_rsp_op;
   logic [DATA_WIDTH-1:0]   w_rsp_data;
   logic [C_ENTRY_W-1:0]    w_push_data;
   logic [C_ENTRY_W-1:0]    w_head;
   logic                    w_full;
   logic                    w_empty;
   logic [C_CNT_W-1:0]      w_count_unused;
   logic                    w_unused_param;

   assign w_unused_param = ^a_param;

   assign a_ready    = reset_n & ~w_full;
   assign w_fire     = a_valid & a_ready;

   assign w_off      = a_address - BASE_ADDR;
   assign w_idx      = w_off[C_LG_MASK +: C_IDX_W];
   assign w_is_get   = (a_opcode == OPCODE_WIDTH'(GET));
   assign w_is_pfull = (a_opcode == OPCODE_WIDTH'(PUT_FULL_DATA));
   assign w_is_put   = w_is_pfull | (a_opcode == OPCODE_WIDTH'(PUT_PARTIAL_DATA));
   assign w_in_range = (a_address >= BASE_ADDR) && ({1'b0, w_off} < C_MEM_BYTES);
   assign w_size_bad = (a_size > C_MAX_SIZE);

   // Alignment and full-lane mask only matter when the size fits the bus.
   always_comb begin
      w_misalign  = 1'b0;
      w_full_mask = '0;
      for (int b = 0; b < C_LG_MASK; b++) begin
         if (a_address[b] && (b < int'(a_size))) begin
            w_misalign = 1'b1;
         end
      end
      for (int i = 0; i < MASK_WIDTH; i++) begin
         w_full_mask[i] = 1'b1;
         for (int b = 0; b < C_LG_MASK; b++) begin
            if ((b >= int'(a_size)) && (((i >> b) & 1) != int'(a_address[b]))) begin
               w_full_mask[i] = 1'b0;
            end
         end
      end
   end

   assign w_error = ~w_in_range | w_size_bad | w_misalign
                  | ~(w_is_get | w_is_put)
                  | (w_is_pfull & (a_mask != w_full_mask));

   assign w_we       = w_fire & w_is_put & ~w_error;
   assign w_rsp_op   = w_is_get ? OPCODE_WIDTH'(ACCESS_ACK_DATA) : OPCODE_WIDTH'(ACCESS_ACK);
   assign w_rsp_data = (w_is_get && !w_error) ? r_mem[w_idx] : '0;

   always_ff @(posedge clk) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
         if (w_we && a_mask[b]) begin
            r_mem[w_idx][b*8 +: 8] <= a_data[b*8 +: 8];
         end
      end
   end

   assign w_push_data = {w_rsp_op, a_size, a_source, w_rsp_data, w_error};

   tlul_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (C_ENTRY_W)
   ) u_resp_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_fire),
      .i_push_data (w_push_data),
      .i_pop       (d_ready),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count_unused)
   );

   assign d_valid = ~w_empty;
   assign {d_opcode, d_size, d_source, d_data, d_error} = w_head;
   assign d_param = '0;
   assign d_sink  = '0;

endmodule

`default_nettype wire

// File: tb/tb_tlul_sram_responder.sv
// ============================================================================
// Module  : tb_tlul_sram_responder
// Brief   : Scoreboard bench: expected D responses queued at A fire, checked at D handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tlul_sram_responder;

   typedef struct {
      logic [2:0]  opcode;
      logic [2:0]  size;
      logic [1:0]  source;
      logic [31:0] data;
      logic        error;
      int          fire_cyc;
      bit          chk_lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [2:0]  a_opcode = '0;
   logic [2:0]  a_param = '0;
   logic [2:0]  a_size = '0;
   logic [1:0]  a_source = '0;
   logic [31:0] a_address = '0;
   logic [3:0]  a_mask = '0;
   logic [31:0] a_data = '0;
   logic        d_valid;
   logic        d_ready = 1'b1;
   logic [2:0]  d_opcode;
   logic [2:0]  d_param;
   logic [2:0]  d_size;
   logic [1:0]  d_source;
   logic [0:0]  d_sink;
   logic [31:0] d_data;
   logic        d_error;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   bit          lat_mode = 1'b0;
   exp_t        sb[$];
   logic [31:0] mdl [1024];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tlul_sram_responder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_opcode  (a_opcode),
      .a_param   (a_param),
      .a_size    (a_size),
      .a_source  (a_source),
      .a_address (a_address),
      .a_mask    (a_mask),
      .a_data    (a_data),
      .d_valid   (d_valid),
      .d_ready   (d_ready),
      .d_opcode  (d_opcode),
      .d_param   (d_param),
      .d_size    (d_size),
      .d_source  (d_source),
      .d_sink    (d_sink),
      .d_data    (d_data),
      .d_error   (d_error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour, evaluated at the fire edge.
   task automatic model_fire();
      exp_t e;
      logic [3:0] fullm;
      int nbytes;
      e.error = 1'b0;
      if (!(a_opcode == 3'd0 || a_opcode == 3'd1 || a_opcode == 3'd4)) e.error = 1'b1;
      if (a_address >= 32'd4096) e.error = 1'b1;
      if (a_size > 3'd2) e.error = 1'b1;
      else if ((a_address % (32'd1 << a_size)) != 0) e.error = 1'b1;
      if (a_opcode == 3'd0 && a_size <= 3'd2) begin
         nbytes = 1 << a_size;
         fullm = 4'(((1 << nbytes) - 1) << (a_address % 4));
         if (a_mask != fullm) e.error = 1'b1;
      end
      e.opcode = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
      e.size   = a_size;
      e.source = a_source;
      e.data   = (a_opcode == 3'd4 && !e.error) ? mdl[a_address >> 2] : 32'h0;
      e.fire_cyc = cyc;
      e.chk_lat  = lat_mode;
      if (!e.error && (a_opcode == 3'd0 || a_opcode == 3'd1)) begin
         for (int b = 0; b < 4; b++)
            if (a_mask[b]) mdl[a_address >> 2][b*8 +: 8] = a_data[b*8 +: 8];
      end
      sb.push_back(e);
   endtask

   // Caller is at posedge+1; returns at posedge+1 just after the fire edge.
   task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                       input logic [3:0] mask, input logic [31:0] data, input logic [1:0] src);
      bit fired = 1'b0;
      int t = 0;
      a_opcode = op; a_address = addr; a_size = size; a_mask = mask; a_data = data;
      a_source = src; a_valid = 1'b1;
      while (!fired && t < 50) begin
         @(negedge clk);
         if (a_ready) begin
            model_fire();
            fired = 1'b1;
         end
         @(posedge clk); #1;
         t++;
      end
      a_valid = 1'b0;
      if (!fired) chk("a_fire_timeout", 64'd0, 64'd1);
   endtask

   always @(negedge clk) begin
      if (reset_n && d_valid && d_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_resp", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("d_opcode", 64'(d_opcode), 64'(e.opcode));
            chk("d_size",   64'(d_size),   64'(e.size));
            chk("d_source", 64'(d_source), 64'(e.source));
            chk("d_data",   64'(d_data),   64'(e.data));
            chk("d_error",  64'(d_error),  64'(e.error));
            chk("d_param_sink", 64'({d_param, d_sink}), 64'd0);
            if (e.chk_lat) chk("latency", 64'(cyc - e.fire_cyc), 64'd1);
         end
      end
   end

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("sb_drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_a_ready", 64'(a_ready), 64'd0);
      chk("rst_d_valid", 64'(d_valid), 64'd0);
      chk("rst_d_fields", 64'({d_opcode, d_size, d_source, d_error}), 64'd0);
      chk("rst_d_data", 64'(d_data), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_rst_a_ready", 64'(a_ready), 64'd1);
      @(posedge clk); #1;

      // Full write then read back
      send(3'd0, 32'h10, 3'd2, 4'hF, 32'hA5A5_A5A5, 2'd2);
      send(3'd4, 32'h10, 3'd2, 4'hF, 32'h0, 2'd2);
      drain();

      // Partial write merges lanes
      send(3'd1, 32'h10, 3'd2, 4'h3, 32'h0000_BEEF, 2'd1);
      send(3'd4, 32'h10, 3'd2, 4'hF, 32'h0, 2'd3);
      drain();

      // Backpressure: third Get held until the FIFO drains
      d_ready = 1'b0;
      send(3'd4, 32'h10, 3'd2, 4'hF, 32'h0, 2'd0);
      send(3'd4, 32'h10, 3'd2, 4'hF, 32'h0, 2'd1);
      @(negedge clk);
      chk("full_a_ready", 64'(a_ready), 64'd0);
      chk("full_d_valid", 64'(d_valid), 64'd1);
      @(posedge clk); #1;
      fork
         send(3'd4, 32'h10, 3'd2, 4'hF, 32'h0, 2'd2);
         begin
            repeat (3) @(negedge clk);
            chk("held_a_ready", 64'(a_ready), 64'd0);
            @(posedge clk); #1;
            d_ready = 1'b1;
         end
      join
      drain();

      // Error cases
      send(3'd4, 32'h1000, 3'd2, 4'hF, 32'h0, 2'd1);
      send(3'd4, 32'h2, 3'd2, 4'hF, 32'h0, 2'd2);
      send(3'd3, 32'h10, 3'd2, 4'hF, 32'hDEAD_DEAD, 2'd3);
      send(3'd0, 32'h10, 3'd2, 4'h3, 32'h1111_1111, 2'd0);
      send(3'd4, 32'h10, 3'd3, 4'hF, 32'h0, 2'd0);
      send(3'd4, 32'h10, 3'd2, 4'hF, 32'h0, 2'd1);
      send(3'd0, 32'h16, 3'd1, 4'hC, 32'h1234_0000, 2'd2);
      send(3'd4, 32'h14, 3'd2, 4'hF, 32'h0, 2'd3);
      drain();

      // Streaming: one Get per cycle, latency one
      for (int i = 0; i < 8; i++)
         send(3'd0, 32'h20 + 32'(i*4), 3'd2, 4'hF, 32'h1357_0000 + 32'(i * 32'h1111), 2'(i));
      drain();
      lat_mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(3'd4, 32'h20 + 32'(i*4), 3'd2, 4'hF, 32'h0, 2'(i));
         chk("stream_fire_cycle", 64'(sb[sb.size()-1].fire_cyc - sb[0].fire_cyc), 64'(sb.size()-1 > 1 ? 1 : sb.size()-1));
      end
      lat_mode = 1'b0;
      drain();

      // Reset with queued responses
      d_ready = 1'b0;
      send(3'd4, 32'h20, 3'd2, 4'hF, 32'h0, 2'd0);
      send(3'd4, 32'h24, 3'd2, 4'hF, 32'h0, 2'd1);
      reset_n = 1'b0;
      #1;
      chk("midrst_d_valid", 64'(d_valid), 64'd0);
      chk("midrst_a_ready", 64'(a_ready), 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      d_ready = 1'b1;
      @(posedge clk); #1;
      send(3'd4, 32'h10, 3'd2, 4'hF, 32'h0, 2'd2);
      send(3'd4, 32'h3C, 3'd2, 4'hF, 32'h0, 2'd3);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
